// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage sitting in front of the IF/ID pipeline register.
// Owns the fetch PC and issues one request at a time to instruction memory over
// a req/ack handshake. Returned words go into a small FIFO so that variable
// memory latency is hidden from the pipeline. Branch/jump redirects from EX
// flush the FIFO and restart fetching at the new target.
//
// Handshake (imem): imem_req rises with imem_addr and both stay stable until
// the cycle in which imem_ack=1. imem_ack closes the request in that same
// cycle, and imem_rdata is valid only in that cycle. Only one request is ever
// outstanding.
//
// Ports
//   clk, rst_n          clock (posedge) and asynchronous active-low reset
//   imem_req/imem_addr  fetch request and its word-aligned address
//   imem_ack/imem_rdata memory completion and returned instruction
//   IF_ID_Stall         IF/ID holds; the head entry is not consumed
//   Redirect/Redirect_PC taken branch/jump in EX; flush and refetch at target
//   IF_valid            FIFO non-empty; instOut/PC are meaningful
//   instOut/PC          head entry (NOP_INST / 0 when empty)
//   dbg_state           current fetch FSM state, for observation only
// -----------------------------------------------------------------------------
module if_fetch_stage #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        IF_ID_Stall,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic        IF_valid,
  output logic [31:0] instOut,
  output logic [31:0] PC,
  output logic [1:0]  dbg_state
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  // S_REQ : request outstanding at fetch_pc
  // S_HOLD: FIFO full, no request
  // S_DROP: request outstanding whose data will be thrown away (redirected)
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   drop_pc_q, drop_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   buf_pc_q   [DEPTH];
  logic [31:0]   buf_pc_d   [DEPTH];
  logic [31:0]   buf_inst_q [DEPTH];
  logic [31:0]   buf_inst_d [DEPTH];

  logic        push;
  logic        pop;
  logic [31:0] redirect_tgt;
  logic        unused_rpc_lsb;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Targets are word aligned; the low two bits of Redirect_PC are ignored.
  assign redirect_tgt   = {Redirect_PC[31:2], 2'b00};
  assign unused_rpc_lsb = ^Redirect_PC[1:0];

  // Redirect suppresses both consumption and capture: the head belongs to a
  // wrong path, and so does any word arriving in the same cycle.
  assign pop  = (count_q != '0) && !IF_ID_Stall && !Redirect;
  assign push = (state_q == S_REQ) && imem_ack && !Redirect;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_pc_d  = drop_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;

    if (push) begin
      buf_pc_d[wr_ptr_q]   = fetch_pc_q;
      buf_inst_d[wr_ptr_q] = imem_rdata;
    end

    if (Redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    case (state_q)
      S_REQ: begin
        if (imem_ack) begin
          if (Redirect) begin
            fetch_pc_d = redirect_tgt;
            state_d    = S_REQ;
          end else begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            // Only issue the next request if a slot is guaranteed for its data.
            state_d    = (count_d < DEPTH_C) ? S_REQ : S_HOLD;
          end
        end else if (Redirect) begin
          // The in-flight request cannot be withdrawn; keep the address
          // stable, remember the target and discard the data when it comes.
          drop_pc_d = redirect_tgt;
          state_d   = S_DROP;
        end
      end
      S_HOLD: begin
        if (Redirect) begin
          fetch_pc_d = redirect_tgt;
          state_d    = S_REQ;
        end else if (count_q < DEPTH_C) begin
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (Redirect) drop_pc_d = redirect_tgt;
        if (imem_ack) begin
          // A redirect arriving together with the ack still wins.
          fetch_pc_d = Redirect ? redirect_tgt : drop_pc_q;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      drop_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc_q[i]   <= '0;
        buf_inst_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_pc_q  <= drop_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
    end
  end

  assign imem_req  = (state_q == S_REQ) || (state_q == S_DROP);
  assign imem_addr = fetch_pc_q;
  assign IF_valid  = (count_q != '0);
  assign instOut   = IF_valid ? buf_inst_q[rd_ptr_q] : NOP_INST;
  assign PC        = IF_valid ? buf_pc_q[rd_ptr_q] : 32'h0000_0000;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Directed bench for if_fetch_stage (DEPTH=2, RESET_PC=0, NOP_INST=0x13).
// A behavioural instruction memory answers each request after mem_lat cycles
// with mem_word(addr). Each scenario task drives its own stimulus and checks
// outputs inline; expected fetch order lives in exp_q.
// All sampling and driving happens one time unit after the falling edge.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

  localparam logic [1:0]  S_REQ  = 2'd0;
  localparam logic [1:0]  S_HOLD = 2'd1;
  localparam logic [1:0]  S_DROP = 2'd2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        IF_ID_Stall;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic        IF_valid;
  logic [31:0] instOut;
  logic [31:0] PC;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 1;
  int mem_cnt  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  if_fetch_stage #(
    .DEPTH(2), .RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .IF_ID_Stall(IF_ID_Stall), .Redirect(Redirect), .Redirect_PC(Redirect_PC),
    .IF_valid(IF_valid), .instOut(instOut), .PC(PC), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required end before 200000");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ {2'b00, a[31:2]};
  endfunction

  // Memory model: counts cycles of an open request, acks after mem_lat of
  // them, then drops ack for one cycle. It resets together with the DUT.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        imem_ack = 1'b0;
        mem_cnt  = 0;
      end else if (imem_ack) begin
        imem_ack = 1'b0;
        mem_cnt  = 0;
      end else if (imem_req) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Returns one time unit after a falling edge with rst_n just released (T0).
  task automatic do_reset(input int lat);
    rst_n       = 1'b0;
    IF_ID_Stall = 1'b0;
    Redirect    = 1'b0;
    Redirect_PC = '0;
    mem_lat     = lat;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n       = 1'b0;
    IF_ID_Stall = 1'b0;
    Redirect    = 1'b0;
    Redirect_PC = '0;
    mem_lat     = 1;
    tick();
    tick();
    n_checks++; if (IF_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", IF_valid); end
    n_checks++; if (instOut !== NOP) begin n_fail++; $display("FAIL reset_inst: got %h expected %h", instOut, NOP); end
    n_checks++; if (PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", PC); end
    n_checks++; if (dbg_state !== S_REQ) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_REQ); end
    rst_n = 1'b1;
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_req: got %b expected 1", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
  endtask

  task automatic test_sequential();
    do_reset(1);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      tick();
      if (IF_valid) begin
        exp_pc = exp_q.pop_front();
        n_checks++; if (PC !== exp_pc) begin n_fail++; $display("FAIL seq_pc: got %h expected %h", PC, exp_pc); end
        n_checks++; if (instOut !== mem_word(exp_pc)) begin n_fail++; $display("FAIL seq_inst: got %h expected %h", instOut, mem_word(exp_pc)); end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL seq_timeout: %0d words missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_ack_latency();
    int  pops;
    logic prev_valid;
    pops       = 0;
    prev_valid = 1'b0;
    do_reset(3);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(4 * i));
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k <= 3) begin
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL lat_req_stable: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
      end
      if (IF_valid) begin
        pops++;
        n_checks++; if (prev_valid !== 1'b0) begin n_fail++; $display("FAIL lat_pulse: valid high in consecutive cycles at step %0d, expected single pulse", k); end
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL lat_extra: got extra word pc=%h expected none", PC);
        end else begin
          exp_pc = exp_q.pop_front();
          n_checks++; if (PC !== exp_pc) begin n_fail++; $display("FAIL lat_pc: got %h expected %h", PC, exp_pc); end
          n_checks++; if (instOut !== mem_word(exp_pc)) begin n_fail++; $display("FAIL lat_inst: got %h expected %h", instOut, mem_word(exp_pc)); end
        end
      end
      prev_valid = IF_valid;
    end
    n_checks++; if (pops != 5) begin n_fail++; $display("FAIL lat_count: got %0d words expected 5", pops); end
  endtask

  task automatic test_stall_full();
    do_reset(1);
    IF_ID_Stall = 1'b1;
    for (int k = 1; k <= 10; k++) tick();
    n_checks++; if (IF_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b expected 1", IF_valid); end
    n_checks++; if (PC !== 32'h0) begin n_fail++; $display("FAIL stall_head_pc: got %h expected 0", PC); end
    n_checks++; if (instOut !== mem_word(32'h0)) begin n_fail++; $display("FAIL stall_head_inst: got %h expected %h", instOut, mem_word(32'h0)); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req: got %b expected 0", imem_req); end
    n_checks++; if (dbg_state !== S_HOLD) begin n_fail++; $display("FAIL stall_state: got %0d expected %0d", dbg_state, S_HOLD); end
    IF_ID_Stall = 1'b0;  // head (pc 0) is consumed at the coming edge
    for (int i = 1; i < 6; i++) exp_q.push_back(32'(4 * i));
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      tick();
      if (IF_valid) begin
        exp_pc = exp_q.pop_front();
        n_checks++; if (PC !== exp_pc) begin n_fail++; $display("FAIL stall_rel_pc: got %h expected %h", PC, exp_pc); end
        n_checks++; if (instOut !== mem_word(exp_pc)) begin n_fail++; $display("FAIL stall_rel_inst: got %h expected %h", instOut, mem_word(exp_pc)); end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_timeout: %0d words missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_redirect_drop();
    do_reset(4);
    tick();
    Redirect    = 1'b1;
    Redirect_PC = 32'h0000_0100;
    tick();
    Redirect = 1'b0;
    n_checks++; if (dbg_state !== S_DROP) begin n_fail++; $display("FAIL drop_state: got %0d expected %0d", dbg_state, S_DROP); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL drop_addr: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    for (int k = 0; k < 30 && exp_q.size() > 0; k++) begin
      tick();
      if (IF_valid) begin
        exp_pc = exp_q.pop_front();
        n_checks++; if (PC !== exp_pc) begin n_fail++; $display("FAIL drop_pc: got %h expected %h", PC, exp_pc); end
        n_checks++; if (instOut !== mem_word(exp_pc)) begin n_fail++; $display("FAIL drop_inst: got %h expected %h", instOut, mem_word(exp_pc)); end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL drop_timeout: %0d words missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_redirect_ack_pop();
    do_reset(1);
    tick();                 // T1: ack for pc 0
    tick();                 // T2: pc 0 at head
    IF_ID_Stall = 1'b1;
    tick();                 // T3: pc 0 still at head, ack for pc 4 this cycle
    n_checks++; if (IF_valid !== 1'b1 || PC !== 32'h0) begin n_fail++; $display("FAIL rap_pre: got valid=%b pc=%h expected valid=1 pc=0", IF_valid, PC); end
    IF_ID_Stall = 1'b0;
    Redirect    = 1'b1;
    Redirect_PC = 32'h0000_0103;
    tick();
    Redirect = 1'b0;
    n_checks++; if (IF_valid !== 1'b0) begin n_fail++; $display("FAIL rap_flush: got %b expected 0", IF_valid); end
    n_checks++; if (instOut !== NOP || PC !== 32'h0) begin n_fail++; $display("FAIL rap_empty_out: got inst=%h pc=%h expected inst=%h pc=0", instOut, PC, NOP); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL rap_addr: got req=%b addr=%h expected req=1 addr=100", imem_req, imem_addr); end
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      tick();
      if (IF_valid) begin
        exp_pc = exp_q.pop_front();
        n_checks++; if (PC !== exp_pc) begin n_fail++; $display("FAIL rap_pc: got %h expected %h", PC, exp_pc); end
        n_checks++; if (instOut !== mem_word(exp_pc)) begin n_fail++; $display("FAIL rap_inst: got %h expected %h", instOut, mem_word(exp_pc)); end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rap_timeout: %0d words missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_pc_wrap();
    do_reset(1);
    Redirect    = 1'b1;
    Redirect_PC = 32'hFFFF_FFFC;
    tick();
    Redirect = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    for (int k = 0; k < 30 && exp_q.size() > 0; k++) begin
      tick();
      if (IF_valid) begin
        exp_pc = exp_q.pop_front();
        n_checks++; if (PC !== exp_pc) begin n_fail++; $display("FAIL wrap_pc: got %h expected %h", PC, exp_pc); end
        n_checks++; if (instOut !== mem_word(exp_pc)) begin n_fail++; $display("FAIL wrap_inst: got %h expected %h", instOut, mem_word(exp_pc)); end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_timeout: %0d words missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_in_drop();
    do_reset(4);
    IF_ID_Stall = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    n_checks++; if (IF_valid !== 1'b1 || PC !== 32'h0) begin n_fail++; $display("FAIL rid_pre: got valid=%b pc=%h expected valid=1 pc=0", IF_valid, PC); end
    tick();                 // T6: request for pc 4 open, no ack yet
    Redirect    = 1'b1;
    Redirect_PC = 32'h0000_0200;
    tick();
    Redirect = 1'b0;
    n_checks++; if (dbg_state !== S_DROP || imem_addr !== 32'h4) begin n_fail++; $display("FAIL rid_drop: got state=%0d addr=%h expected state=%0d addr=4", dbg_state, imem_addr, S_DROP); end
    n_checks++; if (IF_valid !== 1'b0) begin n_fail++; $display("FAIL rid_flush: got %b expected 0", IF_valid); end
    #2;
    rst_n = 1'b0;           // mid-cycle, away from any clock edge
    #1;
    n_checks++; if (dbg_state !== S_REQ) begin n_fail++; $display("FAIL rid_async_state: got %0d expected %0d", dbg_state, S_REQ); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rid_async_addr: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
    n_checks++; if (IF_valid !== 1'b0 || instOut !== NOP || PC !== 32'h0) begin n_fail++; $display("FAIL rid_async_out: got valid=%b inst=%h pc=%h expected 0/%h/0", IF_valid, instOut, PC, NOP); end
    tick();
    rst_n       = 1'b1;
    IF_ID_Stall = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    for (int k = 0; k < 30 && exp_q.size() > 0; k++) begin
      tick();
      if (IF_valid) begin
        exp_pc = exp_q.pop_front();
        n_checks++; if (PC !== exp_pc) begin n_fail++; $display("FAIL rid_pc: got %h expected %h", PC, exp_pc); end
        n_checks++; if (instOut !== mem_word(exp_pc)) begin n_fail++; $display("FAIL rid_inst: got %h expected %h", instOut, mem_word(exp_pc)); end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rid_timeout: %0d words missing, expected 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n       = 1'b0;
    IF_ID_Stall = 1'b0;
    Redirect    = 1'b0;
    Redirect_PC = '0;
    test_reset();
    test_sequential();
    test_ack_latency();
    test_stall_full();
    test_redirect_drop();
    test_redirect_ack_pop();
    test_pc_wrap();
    test_reset_in_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
